// File: rtl/sub_16_serial_pkg.sv
// Shared constants and state encoding for the digit-serial subtractor and the
// CLA adder. Both blocks use the same lookahead slice width.
package sub_16_serial_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int SLICE_DEF  = 4;

  // Number of slice cycles needed for one operation.
  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  localparam int NSLICE_DEF = nslice(WIDTH_DEF, SLICE_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_16_serial_cla.sv
// cla_slice: an N-bit carry-lookahead slice.
// Ports:
//   a, b  : slice operands
//   cin   : carry into the slice
//   s     : slice sum
//   g, p  : group generate and group propagate
//   cout  : carry out of the slice (g | p & cin)
module cla_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         g,
  output logic         p,
  output logic         cout
);

  logic [N-1:0] gi, pi;
  logic [N:0]   c;

  always_comb begin
    gi   = a & b;
    pi   = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) c[i+1] = gi[i] | (pi[i] & c[i]);
    s = pi ^ c[N-1:0];
    // Group terms are independent of cin, so a chain of slices can look ahead.
    g = 1'b0;
    p = 1'b1;
    for (int i = 0; i < N; i++) begin
      g = gi[i] | (pi[i] & g);
      p = p & pi[i];
    end
    cout = g | (p & cin);
  end

endmodule

// File: rtl/sub_16_serial.sv
// sub_16_serial: digit-serial subtractor, d = x - y - bin, computed as
// x + ~y + ~bin, one SLICE-bit lookahead slice per clock, LSB first.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : request, accepted only while busy==0
//   x, y, bin           : operands, captured on an accepted start
//   busy                : high while slices are being computed
//   done                : one-cycle pulse when d/bout/ovf/zero are updated
//   d, bout, ovf, zero  : result, borrow-out, signed overflow, zero flag;
//                         held until the next operation completes
module sub_16_serial
  import sub_16_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] xr, yr;      // yr holds ~y
  logic [WIDTH-1:0] shadow;      // partial difference, hidden from d
  logic [WIDTH-1:0] d_nxt;

  logic [SLICE-1:0] sl_s;
  logic             sl_g, sl_p, sl_cout;
  logic             carry_nxt;
  logic             last;

  cla_slice #(.N(SLICE)) u_slice (
    .a    (xr[cnt*SLICE +: SLICE]),
    .b    (yr[cnt*SLICE +: SLICE]),
    .cin  (carry),
    .s    (sl_s),
    .g    (sl_g),
    .p    (sl_p),
    .cout (sl_cout)
  );

  assign carry_nxt = sl_g | (sl_p & carry);
  assign last      = (cnt == CNT_W'(NSLICE - 1));

  always_comb begin
    d_nxt                   = shadow;
    d_nxt[cnt*SLICE +: SLICE] = sl_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      shadow <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            xr    <= x;
            yr    <= ~y;
            carry <= ~bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          shadow <= d_nxt;
          carry  <= carry_nxt;
          cnt    <= cnt + 1'b1;
          if (last) begin
            // All visible outputs change together, only here.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            d     <= d_nxt;
            bout  <= ~sl_cout;
            // Operand signs differ when xr and ~y share the same MSB.
            ovf   <= (xr[WIDTH-1] == yr[WIDTH-1]) && (d_nxt[WIDTH-1] != xr[WIDTH-1]);
            zero  <= (d_nxt == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
